// File: rtl/rptr_empty_level_if.sv
// +------------------------------------------------------------------+
// | rptr_empty_level_if : read-side FIFO pointer/flag bundle          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface rptr_empty_level_if #(
  parameter int ADDRSIZE = 7
);
  logic                rd_en;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE-1:0] rd_addr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   rd_level;
  logic                rd_valid;
  logic                rd_underflow;

  modport slave (
    input  rd_en, rq2_wptr,
    output rempty, raempty, rd_addr, rptr, rd_level, rd_valid, rd_underflow
  );

  modport master (
    output rd_en, rq2_wptr,
    input  rempty, raempty, rd_addr, rptr, rd_level, rd_valid, rd_underflow
  );
endinterface

`default_nettype wire

// File: rtl/rptr_empty_level.sv
// +------------------------------------------------------------------+
// | rptr_empty_level : async-FIFO read pointer, empty/level flags      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module rptr_empty_level #(
  parameter int ADDRSIZE      = 7,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  rptr_empty_level_if.slave     bus
);

  localparam logic [ADDRSIZE:0] c_AEMPTY = (ADDRSIZE+1)'(AEMPTY_THRESH);
  localparam logic [ADDRSIZE:0] c_ONE    = (ADDRSIZE+1)'(1);

  logic [ADDRSIZE:0] rbin_q,  rbin_d;
  logic [ADDRSIZE:0] rptr_q,  rptr_d;
  logic [ADDRSIZE:0] level_q, level_d;
  logic              rempty_q,    rempty_d;
  logic              raempty_q,   raempty_d;
  logic              rd_valid_q,  rd_valid_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc;
  logic [ADDRSIZE:0] wbin_s;

  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of all bits at or above i.
  for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_wbin
    assign wbin_s[i] = ^bus.rq2_wptr[ADDRSIZE:i];
  end

  always_comb begin
    rd_acc      = bus.rd_en & ~rempty_q;
    rbin_d      = rd_acc ? (rbin_q + c_ONE) : rbin_q;
    rptr_d      = (rbin_d >> 1) ^ rbin_d;
    // Flags look at the post-read pointer so the final read raises empty on the same edge.
    rempty_d    = (rptr_d == bus.rq2_wptr);
    level_d     = wbin_s - rbin_d;
    raempty_d   = (level_d <= c_AEMPTY);
    rd_valid_d  = rd_acc;
    underflow_d = underflow_q | (bus.rd_en & rempty_q);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      rempty_q    <= 1'b1;
      raempty_q   <= 1'b1;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      rempty_q    <= rempty_d;
      raempty_q   <= raempty_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rd_addr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr         = rptr_q;
  assign bus.rd_level     = level_q;
  assign bus.rempty       = rempty_q;
  assign bus.raempty      = raempty_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rptr_empty_level.sv
// +------------------------------------------------------------------+
// | tb_rptr_empty_level : directed + random bench with count model     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_rptr_empty_level;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rptr_empty_level_if #(.ADDRSIZE(7)) bus ();

  rptr_empty_level #(.ADDRSIZE(7), .AEMPTY_THRESH(4)) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model tracks plain counts of entries written and read.
  int wcount   = 0;
  int m_rcount = 0;
  int m_level  = 0;
  bit m_empty  = 1'b1;
  bit m_aempty = 1'b1;
  bit m_valid  = 1'b0;
  bit m_uf     = 1'b0;

  function automatic logic [7:0] gray8(input int b);
    logic [7:0] v;
    v = b[7:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rempty",       32'(bus.rempty),       32'(m_empty));
    chk("raempty",      32'(bus.raempty),      32'(m_aempty));
    chk("rd_level",     32'(bus.rd_level),     32'(m_level));
    chk("rd_addr",      32'(bus.rd_addr),      32'(m_rcount % 128));
    chk("rptr",         32'(bus.rptr),         32'(gray8(m_rcount)));
    chk("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
    chk("rd_underflow", 32'(bus.rd_underflow), 32'(m_uf));
  endtask

  task automatic cycle(input logic rst_v, input logic en_v);
    bit acc;
    rst          = rst_v;
    bus.rd_en    = en_v;
    bus.rq2_wptr = gray8(wcount);
    @(posedge clk);
    if (rst_v) begin
      m_rcount = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1;
      m_valid  = 1'b0; m_uf = 1'b0;
    end else begin
      acc      = en_v && !m_empty;
      m_uf     = m_uf || (en_v && m_empty);
      m_rcount = m_rcount + (acc ? 1 : 0);
      m_level  = wcount - m_rcount;
      m_empty  = (m_level == 0);
      m_aempty = (m_level <= 4);
      m_valid  = acc;
    end
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] prev_rptr;
    logic [6:0] prev_addr;
    int addr_wraps;
    int gray_wraps;
    bit en;

    bus.rd_en    = 1'b0;
    bus.rq2_wptr = '0;
    addr_wraps   = 0;
    gray_wraps   = 0;
    @(negedge clk);

    // Reset held with a pending read and a non-empty write pointer
    wcount = 3;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    chk("release_level", 32'(bus.rd_level), 32'd3);
    chk("release_empty", 32'(bus.rempty),   32'd0);

    // Drain three entries
    for (int i = 0; i < 3; i++) begin
      chk("drain_addr", 32'(bus.rd_addr), 32'(i));
      cycle(1'b0, 1'b1);
      chk("drain_valid", 32'(bus.rd_valid), 32'd1);
      chk("drain_aempty", 32'(bus.raempty), 32'd1);
    end
    chk("drain_empty", 32'(bus.rempty),   32'd1);
    chk("drain_level", 32'(bus.rd_level), 32'd0);

    // Underflow: sticky through idle cycles
    cycle(1'b0, 1'b1);
    chk("uf_valid", 32'(bus.rd_valid),     32'd0);
    chk("uf_flag",  32'(bus.rd_underflow), 32'd1);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0);
    chk("uf_sticky", 32'(bus.rd_underflow), 32'd1);

    // Full FIFO level and almost-empty boundary
    wcount = 0;
    cycle(1'b1, 1'b0);
    chk("rst_uf_clear", 32'(bus.rd_underflow), 32'd0);
    wcount = 128;
    cycle(1'b0, 1'b0);
    chk("full_level",  32'(bus.rd_level), 32'd128);
    chk("full_aempty", 32'(bus.raempty),  32'd0);
    chk("full_empty",  32'(bus.rempty),   32'd0);
    for (int i = 0; i < 124; i++) cycle(1'b0, 1'b1);
    chk("thresh_level",  32'(bus.rd_level), 32'd4);
    chk("thresh_aempty", 32'(bus.raempty),  32'd1);

    // Random traffic across both pointer wraps
    wcount = 0;
    cycle(1'b1, 1'b0);
    for (int n = 0; n < 3000 && m_rcount < 260; n++) begin
      prev_rptr = bus.rptr;
      prev_addr = bus.rd_addr;
      en = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 60 && (wcount - m_rcount) < 128) wcount++;
      cycle(1'b0, en);
      chk("gray_step", 32'($countones(bus.rptr ^ prev_rptr)), 32'(m_valid));
      if (prev_addr == 7'd127 && bus.rd_addr == 7'd0) addr_wraps++;
      if (prev_rptr == 8'h80 && bus.rptr == 8'h00) gray_wraps++;
    end
    chk("addr_wraps", 32'(addr_wraps >= 2), 32'd1);
    chk("gray_wrap",  32'(gray_wraps >= 1), 32'd1);

    // Mid-stream reset with ten entries pending
    wcount = m_rcount + 10;
    cycle(1'b0, 1'b0);
    chk("mid_level", 32'(bus.rd_level), 32'd10);
    cycle(1'b1, 1'b1);
    chk("mid_addr",  32'(bus.rd_addr),  32'd0);
    chk("mid_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_empty", 32'(bus.rempty),   32'd1);
    wcount = 0;
    cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
